// File: rtl/rtr_slice_pkg.sv
// Shared field layout and sizing helpers for the inter-router link slice.
package rtr_slice_pkg;

  // Bit offsets inside one port slice (offset 0 is the MSB end of the slice).
  localparam int CH_VALID_IDX = 0;
  localparam int CH_VC_BASE   = 1;
  localparam int FC_VALID_IDX = 0;
  localparam int FC_VC_BASE   = 1;

  // Counter must hold every value from 0 up to and including buffer_size.
  function automatic int cnt_width(input int buffer_size);
    return $clog2(buffer_size + 1);
  endfunction

endpackage

// File: rtl/rtr_slice_pipe.sv
// Synchronous-reset delay line of DEPTH register stages; all stages clear on reset.
module rtr_slice_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/rtr_link_slice.sv
// Multi-port link register slice with optional downstream credit checking,
// built only when RTR_SLICE_CREDIT_CHECK_EN is defined.
module rtr_link_slice
  import rtr_slice_pkg::*;
#(
  parameter int NUM_PORTS     = 5,
  parameter int NUM_VCS       = 4,
  parameter int CHANNEL_WIDTH = 70,
  parameter int FC_WIDTH      = 1 + $clog2(NUM_VCS),
  parameter int PIPE_DEPTH    = 1,
  parameter int BUFFER_SIZE   = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [0:NUM_PORTS*CHANNEL_WIDTH-1]   channel_in_ip,
  output logic [0:NUM_PORTS*CHANNEL_WIDTH-1]   channel_out_op,
  input  logic [0:NUM_PORTS*FC_WIDTH-1]        flow_ctrl_in_op,
  output logic [0:NUM_PORTS*FC_WIDTH-1]        flow_ctrl_out_ip,
  output logic [NUM_PORTS-1:0]                 error_port,
  output logic                                 error
);

  localparam int VC_IDX_W = $clog2(NUM_VCS);

  // No backpressure on either path: a valid bit is simply carried along with
  // its slice, one flit and one credit per port per cycle.
  rtr_slice_pipe #(.WIDTH(NUM_PORTS*CHANNEL_WIDTH), .DEPTH(PIPE_DEPTH)) u_fwd_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (channel_in_ip),
    .q     (channel_out_op)
  );

  rtr_slice_pipe #(.WIDTH(NUM_PORTS*FC_WIDTH), .DEPTH(PIPE_DEPTH)) u_rev_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (flow_ctrl_in_op),
    .q     (flow_ctrl_out_ip)
  );

`ifdef RTR_SLICE_CREDIT_CHECK_EN
  localparam int                CNT_W    = cnt_width(BUFFER_SIZE);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BUFFER_SIZE);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic                out_valid;
    logic [VC_IDX_W-1:0] out_vc;
    logic                ret_valid;
    logic [VC_IDX_W-1:0] ret_vc;
    logic [NUM_VCS-1:0]  viol;
    logic                err_q;

    // Consumption is seen on the registered output, returns on the raw input.
    assign out_valid = channel_out_op[p*CHANNEL_WIDTH + CH_VALID_IDX];
    assign out_vc    = channel_out_op[p*CHANNEL_WIDTH + CH_VC_BASE +: VC_IDX_W];
    assign ret_valid = flow_ctrl_in_op[p*FC_WIDTH + FC_VALID_IDX];
    assign ret_vc    = flow_ctrl_in_op[p*FC_WIDTH + FC_VC_BASE +: VC_IDX_W];

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      logic             consume;
      logic             give_back;
      logic [CNT_W-1:0] cnt;

      assign consume   = out_valid && (out_vc == VC_IDX_W'(v));
      assign give_back = ret_valid && (ret_vc == VC_IDX_W'(v));

      // Saturating counter: an illegal step is flagged instead of wrapping.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt <= CNT_FULL;
        end else if (consume && !give_back) begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end else if (give_back && !consume) begin
          if (cnt != CNT_FULL) cnt <= cnt + CNT_W'(1);
        end
      end

      assign viol[v] = (consume && !give_back && (cnt == '0)) ||
                       (give_back && !consume && (cnt == CNT_FULL));
    end

    always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_q | (|viol);
    end

    assign error_port[p] = err_q;
  end
`else
  assign error_port = '0;
`endif

  assign error = |error_port;

endmodule
